// File: rtl/pipe_skid_reg_if.sv
// Valid/ready handshake bundle for pipe_skid_reg: an upstream (in_*) channel
// and a downstream (out_*) channel. The slave modport is the buffer itself;
// the master modport is whatever drives and consumes it.
interface pipe_skid_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer (pipeline register with overflow slot).
// The main entry drives out_data; the skid entry catches a word accepted while
// downstream stalls, so in_ready is a pure function of registered state and
// flush and never depends on out_ready. out_valid, out_data and occupancy come
// straight from flops. A saturating counter tracks completed output transfers.
module pipe_skid_reg #(
  parameter int                    DATA_WIDTH  = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  pipe_skid_if.slave             bus,
  input  logic                   flush,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] xfer_count
);

  // Reject meaningless widths at elaboration time.
  if (DATA_WIDTH < 1) begin : g_bad_data_width
    $error("pipe_skid_reg: DATA_WIDTH must be >= 1");
  end
  if (COUNT_WIDTH < 1) begin : g_bad_count_width
    $error("pipe_skid_reg: COUNT_WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   main_data;
  logic [DATA_WIDTH-1:0]   skid_data;
  logic                    out_valid_q;
  logic [1:0]              occupancy_q;
  logic                    accept;
  logic                    transfer;

  // Only in_ready may see a combinational path, and only from flush.
  assign bus.in_ready  = (state != FULL) && !flush;
  assign accept        = bus.in_valid && bus.in_ready;
  assign transfer      = out_valid_q && bus.out_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data;
  assign occupancy     = occupancy_q;

  // Occupancy FSM with registered out_valid/occupancy; flush squashes to EMPTY
  // but leaves the data registers alone since they are invisible when empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      main_data   <= RESET_VALUE;
      skid_data   <= RESET_VALUE;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
    end else if (flush) begin
      state       <= EMPTY;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data   <= bus.in_data;
            state       <= ONE;
            out_valid_q <= 1'b1;
            occupancy_q <= 2'd1;
          end
        end
        ONE: begin
          if (accept && transfer) begin
            // Full-rate streaming: the new word replaces the departing one.
            main_data <= bus.in_data;
          end else if (accept) begin
            skid_data   <= bus.in_data;
            state       <= FULL;
            occupancy_q <= 2'd2;
          end else if (transfer) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (transfer) begin
            main_data   <= skid_data;
            state       <= ONE;
            occupancy_q <= 2'd1;
          end
        end
        default: begin
          state       <= EMPTY;
          out_valid_q <= 1'b0;
          occupancy_q <= 2'd0;
        end
      endcase
    end
  end

  // Saturating transfer counter; a transfer in a flush cycle still counts
  // because downstream has already taken the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      xfer_count <= '0;
    end else if (transfer && (xfer_count != {COUNT_WIDTH{1'b1}})) begin
      xfer_count <= xfer_count + 1'b1;
    end
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 64, width of the payload in bits; elaboration fails if DATA_WIDTH < 1.
REQ-002 SHALL provide parameter RESET_VALUE, default 0 (DATA_WIDTH bits), value loaded into both data registers on reset.
REQ-003 SHALL provide parameter COUNT_WIDTH, default 16, width of the transfer counter; elaboration fails if COUNT_WIDTH < 1.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  DATA_WIDTH  upstream payload.
REQ-009 out_valid  output  1  out_data holds a valid entry.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_data  output  DATA_WIDTH  head-of-buffer payload.
REQ-012 flush  input  1  synchronous discard of all held entries (pipeline squash).
REQ-013 occupancy  output  2  number of held entries (0, 1 or 2).
REQ-014 xfer_count  output  COUNT_WIDTH  number of completed output transfers since reset, saturating.

Function
REQ-015 SHALL hold two entries: main (drives out_data) and skid (overflow); internal state EMPTY, ONE or FULL; occupancy = 0, 1 or 2 respectively.
REQ-016 Input handshake: in_ready = (state != FULL) and not flush; a word is accepted when in_valid and in_ready are both 1 at the rising edge.
REQ-017 Output handshake: out_valid = (state != EMPTY); a transfer completes when out_valid and out_ready are both 1 at the rising edge; out_data = main.
REQ-018 out_valid, out_data and occupancy SHALL be driven from registers only; in_ready is the only output with a combinational path (from flush).
REQ-019 EMPTY: accept -> ONE, main <= in_data; no accept -> stay EMPTY.
REQ-020 ONE: accept and transfer -> stay ONE, main <= in_data (one word per cycle throughput).
REQ-021 ONE: accept, no transfer -> FULL, skid <= in_data, main unchanged.
REQ-022 ONE: transfer, no accept -> EMPTY; neither -> hold.
REQ-023 FULL: transfer -> ONE, main <= skid; no transfer -> hold; no input accepted in FULL.
REQ-024 Latency: an accepted word appears on out_data with out_valid=1 on the cycle after acceptance when the block was EMPTY, or when ONE with a simultaneous transfer; order is strictly FIFO.
REQ-025 flush=1 at a rising edge SHALL force state EMPTY regardless of in_valid/out_ready; no input is accepted that cycle; main and skid retain their contents (not observable because out_valid=0).
REQ-026 A transfer coinciding with flush SHALL still increment xfer_count (downstream already sampled it); the held entries are then discarded.
REQ-027 xfer_count increments by 1 per completed transfer and saturates at 2^COUNT_WIDTH - 1 (no wrap).
REQ-028 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 No word is ever dropped or duplicated except by flush.

Reset
REQ-030 While reset=0, asynchronously: state EMPTY, main = skid = RESET_VALUE, xfer_count = 0; hence out_valid=0, occupancy=0, out_data=RESET_VALUE, in_ready=1 when flush=0.
REQ-031 Reset asserted mid-operation (ONE or FULL) SHALL discard all entries immediately without waiting for a clock edge.
REQ-032 After reset release, first acceptance possible at the first rising edge with reset=1.

Verification
REQ-033 Reset, then in_valid=1 data 0xA5 with out_ready=1 -> next cycle out_valid=1, out_data=0xA5, occupancy=1; xfer_count=1 one cycle later.
REQ-034 out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0, out_data=0x11; a third word 0x33 held on in_valid is not accepted; out_ready=1 -> outputs 0x11, 0x22, 0x33 in order, no loss.
REQ-035 Streaming 100 consecutive words with in_valid=out_ready=1 -> one transfer per cycle, occupancy stays 1, xfer_count=100.
REQ-036 FULL with flush=1 and in_valid=1 data 0x77 -> next cycle out_valid=0, occupancy=0, 0x77 never emitted; xfer_count unchanged if out_ready=0.
REQ-037 COUNT_WIDTH=2, complete 5 transfers -> xfer_count reads 3 after the third and stays 3.
REQ-038 Assert reset=0 between clock edges while FULL -> out_valid=0, out_data=RESET_VALUE, occupancy=0 before the next rising edge.
